// File: rtl/motor_relu_stream.sv
// Pipelined streaming activation stage: per-lane ReLU / clipped ReLU / leaky ReLU / passthrough,
// two register stages, valid/ready with full backpressure. Optional counters under MOTOR_RELU_STAT_EN.

module motor_relu_lane #(
  parameter int                    W          = 16,
  parameter logic signed [W-1:0]   CLIP       = 16'sh0C00,
  parameter int                    LEAK_SHIFT = 3
) (
  input  logic signed [W-1:0] x,
  input  logic [1:0]          mode,
  output logic [W-1:0]        y
`ifdef MOTOR_RELU_STAT_EN
  ,output logic               is_zero,
  output logic                is_clip
`endif
);
  logic neg, nonpos;
  assign neg    = x[W-1];
  assign nonpos = neg || (x == '0);

  always_comb begin
    y = x;
    case (mode)
      2'd0: if (neg) y = '0;
      2'd1: begin
        if (nonpos)        y = '0;
        else if (x > CLIP) y = CLIP;
      end
      2'd2: if (neg) y = x >>> LEAK_SHIFT;
      default: y = x;
    endcase
  end

`ifdef MOTOR_RELU_STAT_EN
  // only negative inputs are actually forced; zero passes through unchanged
  assign is_zero = (mode == 2'd0 || mode == 2'd1) && neg;
  assign is_clip = (mode == 2'd1) && !nonpos && (x > CLIP);
`endif
endmodule

module motor_relu_stream #(
  parameter int                    W          = 16,
  parameter int                    FRAC       = 9,
  parameter int                    N_CH       = 3,
  parameter logic signed [W-1:0]   CLIP       = W'(6 << FRAC),
  parameter int                    LEAK_SHIFT = 3
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [W*N_CH-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic [1:0]          mode,
  output logic [W*N_CH-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
`ifdef MOTOR_RELU_STAT_EN
  ,input  logic               stat_clr,
  output logic [31:0]         stat_zero,
  output logic [31:0]         stat_clip
`endif
);
  localparam int STAGES = 2;

  logic [N_CH-1:0][W-1:0] lane_y, d1, d2;
  logic [STAGES:1]        vld_pipe;
  logic                   l1, l2;
  logic                   en1, en2, xfer_in;

  assign en2      = !vld_pipe[2] || out_ready;
  assign en1      = !vld_pipe[1] || en2;
  assign in_ready = en1;
  assign xfer_in  = in_valid && en1;

`ifdef MOTOR_RELU_STAT_EN
  logic [N_CH-1:0] lane_zero, lane_clip;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    motor_relu_lane #(.W(W), .CLIP(CLIP), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .x    (in_data[k*W +: W]),
      .mode (mode),
      .y    (lane_y[k])
`ifdef MOTOR_RELU_STAT_EN
      ,.is_zero (lane_zero[k]),
      .is_clip  (lane_clip[k])
`endif
    );
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_pipe <= '0;
      d1       <= '0;
      d2       <= '0;
      l1       <= 1'b0;
      l2       <= 1'b0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (xfer_in) begin
        d1 <= lane_y;
        l1 <= in_last;
      end
      if (en2) begin
        vld_pipe[2] <= vld_pipe[1];
        // a bubble only clears the valid bit; data/last hold their last value
        if (vld_pipe[1]) begin
          d2 <= d1;
          l2 <= l1;
        end
      end
    end
  end

  assign out_data  = d2;
  assign out_last  = l2;
  assign out_valid = vld_pipe[2];

`ifdef MOTOR_RELU_STAT_EN
  logic [6:0]  zero_cnt, clip_cnt;
  logic [32:0] zero_sum, clip_sum;

  always_comb begin
    zero_cnt = '0;
    clip_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      zero_cnt = zero_cnt + 7'(lane_zero[i]);
      clip_cnt = clip_cnt + 7'(lane_clip[i]);
    end
    zero_sum = {1'b0, stat_zero} + 33'(zero_cnt);
    clip_sum = {1'b0, stat_clip} + 33'(clip_cnt);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || stat_clr) begin
      stat_zero <= '0;
      stat_clip <= '0;
    end else if (xfer_in) begin
      stat_zero <= zero_sum[32] ? 32'hFFFF_FFFF : zero_sum[31:0];
      stat_clip <= clip_sum[32] ? 32'hFFFF_FFFF : clip_sum[31:0];
    end
  end
`endif
endmodule
